// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RV32I datapath with a shared instruction/data memory port.
// Moore state outputs plus a funct decode; write enables are masked while reset_n is low.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic [2:0] alucontrol,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [3:0] r_state;
  logic       r_illegal;
  logic [3:0] w_next;
  logic [2:0] w_functAlu;
  logic       w_pcwrite;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regwrite;
  logic       w_retire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_TRAP) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEMADR:   w_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI, S_JAL: w_next = S_ALUWB;
      S_ALUWB, S_MEMWB, S_BEQ: w_next = S_FETCH;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

  // Subtract only for R-type (op[5]) with instr[30]; addi ignores that bit.
  always_comb begin
    w_functAlu = ALU_ADD;
    case (funct3)
      3'b000:  w_functAlu = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  w_functAlu = ALU_SLT;
      3'b110:  w_functAlu = ALU_OR;
      3'b111:  w_functAlu = ALU_AND;
      default: w_functAlu = ALU_ADD;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   immsrc = 2'b01;
      OP_BEQ:  immsrc = 2'b10;
      OP_JAL:  immsrc = 2'b11;
      default: immsrc = 2'b00;
    endcase
  end

  always_comb begin
    w_pcwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_retire   = 1'b0;
    adrsrc     = 1'b0;
    resultsrc  = 2'b00;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    alucontrol = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        w_irwrite = mem_ready;
        w_pcwrite = mem_ready;
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      S_MEMREAD: adrsrc = 1'b1;
      S_MEMWRITE: begin
        adrsrc     = 1'b1;
        w_memwrite = 1'b1;
        w_retire   = mem_ready;
      end
      S_MEMWB: begin
        resultsrc  = 2'b01;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_EXECR: begin
        alusrca    = 2'b10;
        alucontrol = w_functAlu;
      end
      S_EXECI: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b01;
        alucontrol = w_functAlu;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_BEQ: begin
        alusrca    = 2'b10;
        alucontrol = ALU_SUB;
        w_pcwrite  = zero;
        w_retire   = 1'b1;
      end
      S_JAL: begin
        alusrca   = 2'b01;
        alusrcb   = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcwrite  = w_pcwrite  & reset_n;
  assign memwrite = w_memwrite & reset_n;
  assign irwrite  = w_irwrite  & reset_n;
  assign regwrite = w_regwrite & reset_n;
  assign retire   = w_retire   & reset_n;
  assign illegal  = r_illegal;
  assign state    = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: walks each instruction class through
// its state sequence and checks decoded controls against hand-computed values.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, retire, illegal;
  logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;
  int retireCount;
  int memwriteCount;

  localparam logic [3:0] expLw [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pcwrite(pcwrite), .adrsrc(adrsrc),
    .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb), .immsrc(immsrc),
    .alucontrol(alucontrol), .retire(retire), .illegal(illegal), .state(state)
  );

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                               input logic z, input logic mr);
    op = o; funct3 = f3; funct7b5 = f7; zero = z; mem_ready = mr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    applyStimulus(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b1);
    #10;
    checkOutput("rst_state", 16'(state), 16'd0);
    checkOutput("rst_irwrite", 16'(irwrite), 16'd0);
    checkOutput("rst_pcwrite", 16'(pcwrite), 16'd0);
    checkOutput("rst_alusrcb", 16'(alusrcb), 16'd2);
    checkOutput("rst_illegal", 16'(illegal), 16'd0);
    reset_n = 1'b1;
    #1;
    checkOutput("fetch_irwrite", 16'(irwrite), 16'd1);
    checkOutput("fetch_pcwrite", 16'(pcwrite), 16'd1);
    checkOutput("fetch_resultsrc", 16'(resultsrc), 16'd2);

    // R-type funct decode while parked in EXECR
    tick();
    checkOutput("dec_state", 16'(state), 16'd1);
    checkOutput("dec_alusrca", 16'(alusrca), 16'd1);
    checkOutput("dec_alusrcb", 16'(alusrcb), 16'd1);
    tick();
    checkOutput("execr_state", 16'(state), 16'd6);
    checkOutput("execr_sub", 16'(alucontrol), 16'd1);
    checkOutput("execr_alusrca", 16'(alusrca), 16'd2);
    applyStimulus(7'b0110011, 3'b111, 1'b0, 1'b0, 1'b1);
    checkOutput("execr_and", 16'(alucontrol), 16'd2);
    applyStimulus(7'b0110011, 3'b010, 1'b0, 1'b0, 1'b1);
    checkOutput("execr_slt", 16'(alucontrol), 16'd5);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_state", 16'(state), 16'd0);
    checkOutput("midrst_regwrite", 16'(regwrite), 16'd0);
    checkOutput("midrst_irwrite", 16'(irwrite), 16'd0);
    checkOutput("midrst_pcwrite", 16'(pcwrite), 16'd0);
    reset_n = 1'b1;
    #1;
    checkOutput("rel_irwrite", 16'(irwrite), 16'd1);

    // lw with zero wait states
    applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b1);
    retireCount = 0;
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("lw_state%0d", i), 16'(state), 16'(expLw[i]));
      checkOutput($sformatf("lw_regwrite%0d", i), 16'(regwrite), (i == 4) ? 16'd1 : 16'd0);
      if (i == 3) checkOutput("lw_adrsrc", 16'(adrsrc), 16'd1);
      if (i == 4) checkOutput("lw_resultsrc", 16'(resultsrc), 16'd1);
      if (i < 5) begin
        retireCount += int'(retire);
        tick();
      end
    end
    checkOutput("lw_retires", 16'(retireCount), 16'd1);

    // sw with three wait cycles in MEMWRITE
    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("sw_immsrc", 16'(immsrc), 16'd1);
    tick();
    checkOutput("sw_memadr", 16'(state), 16'd2);
    tick();
    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
    memwriteCount = 0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("sw_wait_state%0d", i), 16'(state), 16'd5);
      checkOutput($sformatf("sw_wait_retire%0d", i), 16'(retire), 16'd0);
      checkOutput($sformatf("sw_wait_adrsrc%0d", i), 16'(adrsrc), 16'd1);
      memwriteCount += int'(memwrite);
      tick();
    end
    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
    memwriteCount += int'(memwrite);
    checkOutput("sw_memwrites", 16'(memwriteCount), 16'd4);
    checkOutput("sw_retire", 16'(retire), 16'd1);
    tick();
    checkOutput("sw_done_state", 16'(state), 16'd0);
    checkOutput("sw_done_memwrite", 16'(memwrite), 16'd0);

    // addi with instr[30] set still adds
    applyStimulus(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("execi_state", 16'(state), 16'd7);
    checkOutput("execi_add", 16'(alucontrol), 16'd0);
    checkOutput("execi_alusrcb", 16'(alusrcb), 16'd1);
    tick();
    checkOutput("aluwb_state", 16'(state), 16'd8);
    checkOutput("aluwb_regwrite", 16'(regwrite), 16'd1);
    checkOutput("aluwb_retire", 16'(retire), 16'd1);
    tick();
    checkOutput("execi_done", 16'(state), 16'd0);

    // beq taken then not taken
    for (int z = 1; z >= 0; z--) begin
      applyStimulus(7'b1100011, 3'b000, 1'b0, 1'(z), 1'b1);
      tick();
      checkOutput($sformatf("beq%0d_immsrc", z), 16'(immsrc), 16'd2);
      tick();
      checkOutput($sformatf("beq%0d_state", z), 16'(state), 16'd9);
      checkOutput($sformatf("beq%0d_pcwrite", z), 16'(pcwrite), 16'(z));
      checkOutput($sformatf("beq%0d_sub", z), 16'(alucontrol), 16'd1);
      checkOutput($sformatf("beq%0d_retire", z), 16'(retire), 16'd1);
      tick();
      checkOutput($sformatf("beq%0d_done", z), 16'(state), 16'd0);
    end

    // jal
    applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("jal_state", 16'(state), 16'd10);
    checkOutput("jal_pcwrite", 16'(pcwrite), 16'd1);
    checkOutput("jal_alusrca", 16'(alusrca), 16'd1);
    checkOutput("jal_alusrcb", 16'(alusrcb), 16'd2);
    checkOutput("jal_immsrc", 16'(immsrc), 16'd3);
    tick();
    checkOutput("jal_aluwb", 16'(state), 16'd8);
    tick();
    checkOutput("jal_done", 16'(state), 16'd0);

    // fetch wait state
    applyStimulus(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("fwait_irwrite", 16'(irwrite), 16'd0);
    tick();
    checkOutput("fwait_state", 16'(state), 16'd0);
    applyStimulus(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("trap_decode", 16'(state), 16'd1);
    checkOutput("trap_preillegal", 16'(illegal), 16'd0);
    tick();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(7'b0000000, 3'b000, 1'b0, 1'b0, 1'(i % 2));
      checkOutput($sformatf("trap_state%0d", i), 16'(state), 16'd11);
      checkOutput($sformatf("trap_illegal%0d", i), 16'(illegal), 16'd1);
      tick();
    end
    reset_n = 1'b0;
    #1;
    checkOutput("trap_rst_state", 16'(state), 16'd0);
    checkOutput("trap_rst_illegal", 16'(illegal), 16'd0);
    reset_n = 1'b1;
    tick();
    checkOutput("trap_after_state", 16'(state), 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control FSM that sequences a multicycle RV32I datapath through fetch, decode, execute, memory and writeback states. Instructions and data share one memory port. It decodes opcode/funct fields from the instruction register. It drives the datapath's mux selects, write enables and ALU function, and stalls on a memory ready handshake. Supported instructions: lw, sw, R-type ALU, I-type ALU, beq, jal.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- op  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- pcwrite  out  1  PC register load enable
- adrsrc  out  1  memory address select: 0 = PC, 1 = ALU output register
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register (and old-PC) load enable
- regwrite  out  1  register file write enable
- resultsrc  out  2  00 ALUOut reg, 01 read data reg, 10 ALU result
- alusrca  out  2  00 PC, 01 old PC, 10 rs1 reg
- alusrcb  out  2  00 rs2 reg, 01 immediate, 10 constant 4
- immsrc  out  2  00 I, 01 S, 10 B, 11 J
- alucontrol  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- retire  out  1  one-cycle pulse in last cycle of each instruction
- illegal  out  1  sticky illegal-opcode flag
- state  out  4  current state encoding (debug)

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10, TRAP 11. Encodings 12–15 are unreachable. If entered, the next state is FETCH.
- Transitions:
  - FETCH→DECODE when mem_ready, else stay.
  - DECODE dispatches on op: 0000011/0100011→MEMADR, 0110011→EXECR, 0010011→EXECI, 1100011→BEQ, 1101111→JAL, any other→TRAP.
  - MEMADR→MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD→MEMWB on mem_ready, else stay.
  - MEMWRITE→FETCH on mem_ready, else stay.
  - EXECR/EXECI/JAL→ALUWB.
  - ALUWB/MEMWB/BEQ→FETCH.
  - TRAP→TRAP until reset.
- Per-state outputs (Moore; all unlisted outputs 0, alucontrol defaults to add):
  - FETCH: adrsrc 0, alusrca 00, alusrcb 10, add, resultsrc 10; irwrite = pcwrite = mem_ready.
  - DECODE: alusrca 01, alusrcb 01, add. This precomputes the branch target.
  - MEMADR: alusrca 10, alusrcb 01, add.
  - MEMREAD: adrsrc 1.
  - MEMWRITE: adrsrc 1, memwrite 1. memwrite is held every cycle until mem_ready.
  - MEMWB: resultsrc 01, regwrite 1.
  - EXECR: alusrca 10, alusrcb 00, funct decode.
  - EXECI: alusrca 10, alusrcb 01, funct decode.
  - ALUWB: resultsrc 00, regwrite 1.
  - BEQ: alusrca 10, alusrcb 00, sub, resultsrc 00, pcwrite = zero.
  - JAL: alusrca 01, alusrcb 10, add, resultsrc 00, pcwrite 1.
  - TRAP: illegal 1.
- immsrc is a combinational decode of op in every state:
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - else → 00
- Funct decode (EXECR/EXECI):
  - funct3 000: sub if op[5] & funct7b5, else add.
  - 010 → slt; 110 → or; 111 → and; any other funct3 → add.
- retire = 1 in:
  - MEMWB, ALUWB, BEQ;
  - MEMWRITE when mem_ready.

## Timing
- State register updates on the rising clk edge. Outputs are combinational from state and op/funct/zero/mem_ready. There is no output register.
- reset_n low asynchronously forces state = FETCH and clears illegal. While reset_n is low, pcwrite, irwrite, regwrite, memwrite and retire are forced to 0; other outputs show FETCH values.
- Cycle counts with zero wait states (mem_ready = 1 throughout):
  - lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3.
  - Each wait cycle in FETCH/MEMREAD/MEMWRITE adds 1.
- mem_ready is sampled only in FETCH, MEMREAD and MEMWRITE, and ignored elsewhere.
- Reset asserted mid-instruction abandons the instruction. No write enable is asserted after reset_n falls.
- illegal is set on entry to TRAP and stays 1 until reset.

## Test plan
- Reset: reset_n low mid-EXECR → state 0 immediately, all enables 0. After release with mem_ready = 1, irwrite = pcwrite = 1 in the first cycle.
- lw, mem_ready = 1: state sequence 0,1,2,3,4,0. regwrite only in state 4 with resultsrc 01. retire pulses once.
- sw with mem_ready low 3 cycles in MEMWRITE: memwrite = 1 for 4 consecutive cycles, adrsrc 1. retire only in the mem_ready cycle.
- R-type: funct3 000, funct7b5 1 → alucontrol 001. funct3 111 → 010. funct3 010 → 101. I-type addi with instr[30] = 1 → 000.
- beq: zero = 1 → pcwrite 1 in state 9. zero = 0 → pcwrite 0. Both return to FETCH after 3 cycles.
- op 0000000 → DECODE→TRAP. illegal = 1 and state 11 held for 10+ cycles with mem_ready toggling. Reset clears both.
